// File: rtl/ps2_kbd_rx_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   ps2_state_e    frame FSM states
//   PS2_EXT        0xE0 extended-key prefix
//   PS2_BRK        0xF0 break (key release) prefix
//   PS2_PAUSE      0xE1 Pause-key sequence introducer
//   PS2_PAUSE_LEN  bytes swallowed after 0xE1 before the Pause event
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT       = 8'hE0;
   localparam logic [7:0] PS2_BRK       = 8'hF0;
   localparam logic [7:0] PS2_PAUSE     = 8'hE1;
   localparam int         PS2_PAUSE_LEN = 7;

   // PS/2 uses odd parity over the eight data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: bundle between the I/O bridge / keyboard mapper and the
// PS/2 receiver.
//   ps2_clk, ps2_data   emulated PS/2 pair (asynchronous to clk_sys)
//   raw_strobe/raw_byte every good frame byte
//   key_strobe/key_code/key_ext/key_released  decoded make/break event
//   frame_err           parity, stop-bit or timeout failure pulse
// master: bridge + mapper side.  slave: the receiver.
interface ps2_kbd_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       raw_strobe;
   logic [7:0] raw_byte;
   logic       key_strobe;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_released;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  raw_strobe, raw_byte, key_strobe, key_code, key_ext,
             key_released, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output raw_strobe, raw_byte, key_strobe, key_code, key_ext,
             key_released, frame_err
   );
endinterface

// File: rtl/ps2_kbd_rx_edge_filter.sv
// ps2_edge_filter: 2-flop synchroniser, debounce and fall detector for the
// PS/2 clock line.
//   clk_sys  system clock
//   reset    synchronous, active-high
//   line_i   raw asynchronous line
//   fall_o   one-cycle pulse on an accepted 1->0 transition
// The filtered level only moves after FILTER consecutive synchronised
// samples disagree with it; it resets to 1 (idle PS/2 line).
module ps2_edge_filter #(
   parameter int FILTER = 4
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic line_i,
   output logic fall_o
);

   localparam int CW = $clog2(FILTER + 1);

   logic [1:0]    sync_q;
   logic          level_q, level_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      level_d = level_q;
      fall_d  = 1'b0;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CW'(FILTER - 1)) begin
            level_d = sync_q[1];
            fall_d  = level_q;            // was high, now accepted low
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], line_i};
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fall_o = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver between the I/O bridge and the PET
// keyboard-matrix mapper.
//   clk_sys  system clock, all logic on posedge
//   reset    synchronous, active-high, overrides everything
//   bus      ps2_kbd_rx_if.slave (PS/2 pair in, raw byte / key event out)
// Deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop),
// strips E0/F0 prefixes and collapses the 8-byte Pause sequence into one
// E1 event.  key_strobe lags raw_strobe by exactly one cycle.
// Optional: define PS2_RX_TIMEOUT_EN to abort frames stalled for TIMEOUT
// cycles without a clock fall.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FILTER  = 4,
   parameter int TIMEOUT = 2048
) (
   input  logic        clk_sys,
   input  logic        reset,
   ps2_kbd_rx_if.slave bus
);

   logic       fall;
   logic [1:0] data_sync_q;
   logic       data_s;

   ps2_state_e state_q, state_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [7:0] sr_q, sr_d;
   logic       par_q, par_d;

   logic       raw_strobe_q, raw_strobe_d;
   logic [7:0] raw_byte_q, raw_byte_d;
   logic       frame_err_q, frame_err_d;

   logic [2:0] skip_q, skip_d;
   logic       ext_f_q, ext_f_d;
   logic       rel_f_q, rel_f_d;
   logic       key_strobe_q, key_strobe_d;
   logic [7:0] key_code_q, key_code_d;
   logic       key_ext_q, key_ext_d;
   logic       key_rel_q, key_rel_d;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
   // TIMEOUT only matters when the stall counter is built in.
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
`endif

   ps2_edge_filter #(.FILTER(FILTER)) u_clk_filter (
      .clk_sys (clk_sys),
      .reset   (reset),
      .line_i  (bus.ps2_clk),
      .fall_o  (fall)
   );

   // Data is stable for a whole half-period around the fall, so the
   // synchroniser alone is enough; its shorter latency does not matter.
   assign data_s = data_sync_q[1];

   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      sr_d         = sr_q;
      par_d        = par_q;
      raw_strobe_d = 1'b0;
      raw_byte_d   = raw_byte_q;
      frame_err_d  = 1'b0;
      skip_d       = skip_q;
      ext_f_d      = ext_f_q;
      rel_f_d      = rel_f_q;
      key_strobe_d = 1'b0;
      key_code_d   = key_code_q;
      key_ext_d    = key_ext_q;
      key_rel_d    = key_rel_q;
`ifdef PS2_RX_TIMEOUT_EN
      to_cnt_d     = to_cnt_q;
`endif

      // Frame FSM, advanced only on an accepted clock fall.
      if (fall) begin
         case (state_q)
            IDLE: begin
               if (!data_s) begin        // a high start bit is line noise
                  state_d  = DATA;
                  bitcnt_d = '0;
               end
            end
            DATA: begin
               sr_d     = {data_s, sr_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = data_s;
               state_d = STOP;
            end
            STOP: begin
               if (data_s && odd_parity_ok(sr_q, par_q)) begin
                  raw_byte_d   = sr_q;
                  raw_strobe_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Prefix decoder, one cycle behind the raw byte.  The Pause tail is
      // swallowed wholesale, including any E0/F0 bytes inside it.
      if (raw_strobe_q) begin
         if (skip_q != '0) begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
               key_strobe_d = 1'b1;
               key_code_d   = PS2_PAUSE;
               key_ext_d    = 1'b0;
               key_rel_d    = 1'b0;
            end
         end else if (raw_byte_q == PS2_PAUSE) begin
            skip_d = 3'(PS2_PAUSE_LEN);
         end else if (raw_byte_q == PS2_EXT) begin
            ext_f_d = 1'b1;
         end else if (raw_byte_q == PS2_BRK) begin
            rel_f_d = 1'b1;
         end else begin
            key_strobe_d = 1'b1;
            key_code_d   = raw_byte_q;
            key_ext_d    = ext_f_q;
            key_rel_d    = rel_f_q;
            ext_f_d      = 1'b0;
            rel_f_d      = 1'b0;
         end
      end

`ifdef PS2_RX_TIMEOUT_EN
      // Stall watchdog; placed last so an abort wins over the assignments
      // above.  A stray half-byte also invalidates any pending prefix.
      if (fall || state_q == IDLE) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
         to_cnt_d    = '0;
         state_d     = IDLE;
         sr_d        = '0;
         frame_err_d = 1'b1;
         ext_f_d     = 1'b0;
         rel_f_d     = 1'b0;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
`endif
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         data_sync_q  <= 2'b11;
         state_q      <= IDLE;
         bitcnt_q     <= '0;
         sr_q         <= '0;
         par_q        <= 1'b0;
         raw_strobe_q <= 1'b0;
         raw_byte_q   <= '0;
         frame_err_q  <= 1'b0;
         skip_q       <= '0;
         ext_f_q      <= 1'b0;
         rel_f_q      <= 1'b0;
         key_strobe_q <= 1'b0;
         key_code_q   <= '0;
         key_ext_q    <= 1'b0;
         key_rel_q    <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
         to_cnt_q     <= '0;
`endif
      end else begin
         data_sync_q  <= {data_sync_q[0], bus.ps2_data};
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         sr_q         <= sr_d;
         par_q        <= par_d;
         raw_strobe_q <= raw_strobe_d;
         raw_byte_q   <= raw_byte_d;
         frame_err_q  <= frame_err_d;
         skip_q       <= skip_d;
         ext_f_q      <= ext_f_d;
         rel_f_q      <= rel_f_d;
         key_strobe_q <= key_strobe_d;
         key_code_q   <= key_code_d;
         key_ext_q    <= key_ext_d;
         key_rel_q    <= key_rel_d;
`ifdef PS2_RX_TIMEOUT_EN
         to_cnt_q     <= to_cnt_d;
`endif
      end
   end

   assign bus.raw_strobe   = raw_strobe_q;
   assign bus.raw_byte     = raw_byte_q;
   assign bus.key_strobe   = key_strobe_q;
   assign bus.key_code     = key_code_q;
   assign bus.key_ext      = key_ext_q;
   assign bus.key_released = key_rel_q;
   assign bus.frame_err    = frame_err_q;

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Consumes the emulated PS/2 keyboard pair (ps2_kbd_clk/ps2_kbd_data) produced by the I/O controller bridge.
- Deserialises 11-bit PS/2 frames and strips the E0/F0/E1 prefixes.
- Emits one key event per make/break on the core clock.
- Sits between the I/O bridge and the PET keyboard-matrix mapper.

Parameters:
- FILTER, 4: consecutive identical synchronised samples required before a ps2_clk level change is accepted.
- TIMEOUT, 2048: clk_sys cycles without a filtered ps2_clk fall, mid-frame, before the frame is aborted. Only used with PS2_RX_TIMEOUT_EN.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from the bridge; asynchronous to clk_sys.
- ps2_data  in  1  PS/2 data from the bridge; asynchronous to clk_sys.
- raw_strobe  out  1  one-cycle pulse when a valid frame byte is received.
- raw_byte  out  8  last valid frame byte; held between strobes.
- key_strobe  out  1  one-cycle pulse per decoded key event.
- key_code  out  8  scancode of the event; held.
- key_ext  out  1  event was E0-prefixed; held.
- key_released  out  1  event was F0-prefixed (break); held.
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout failure.

Behaviour:
- Interface fixed: one clock clk_sys; reset is synchronous, active-high.
- Reset:
  - All outputs 0; FSM to IDLE; prefix flags, skip counter and shift register cleared.
  - Reset has priority over every other event, including mid-frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - Filtered clock level changes only after FILTER equal consecutive samples. Filtered level resets to 1.
  - fall = filtered 1→0 transition, one cycle wide.
  - Data is sampled from the synchronised ps2_data on the fall cycle.
- Frame FSM (advances only on fall):
  - IDLE: data=0 → DATA with bitcnt=0; data=1 → stay in IDLE, no error.
  - DATA: shift LSB-first into sr[7:0]; bitcnt+1; after the 8th bit → PARITY.
  - PARITY: capture p → STOP.
  - STOP:
    - if data=1 and ^{sr,p}=1 (odd parity): raw_byte<=sr and raw_strobe=1 on the next cycle.
    - otherwise: frame_err=1 on the next cycle, no raw_strobe.
    - → IDLE in both cases.
- Decoder (evaluates raw_byte in the cycle after raw_strobe; key_strobe lags raw_strobe by exactly 1 cycle):
  - skip>0: skip-1. When skip reaches 0: key_strobe with key_code=E1, ext=0, rel=0.
  - E1: skip<=7; no strobe.
  - E0: ext_f<=1; no strobe.
  - F0: rel_f<=1; no strobe.
  - Any other byte: key_strobe=1, key_code=byte, key_ext=ext_f, key_released=rel_f; then ext_f, rel_f cleared.
  - Prefix order E0 F0 and F0 E0 both set the same flags.
  - A repeated prefix is idempotent.
- frame_err does not clear prefix flags or the skip counter.
- A fall arriving while the decoder is busy is still captured: the decoder is single-cycle, so there is no backpressure and no buffering.

Optional Feature:
- PS2_RX_TIMEOUT_EN defined:
  - Counter clears on every fall and increments while the FSM is not in IDLE.
  - On reaching TIMEOUT: FSM→IDLE, frame_err pulse, shift register cleared; prefix flags also cleared.
  - Counter width is $clog2(TIMEOUT+1).
- Undefined: no counter is present; a stalled frame waits indefinitely for further falls.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum {IDLE, DATA, PARITY, STOP};
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_PAUSE_LEN=7.
- One sub-module, ps2_edge_filter (synchroniser, FILTER debounce, fall detect), instantiated once for clk.
- The data line gets the 2-flop synchroniser only.

Test Plan:
- Frame 0x1C (start 0, bits 00111000 LSB-first, parity 0, stop 1), half-period 101 cycles → raw_strobe with raw_byte=1C; key_strobe one cycle later with code=1C, ext=0, rel=0.
- Bytes F0,1C → one raw_strobe per byte; a single key_strobe with code=1C, rel=1, ext=0.
- Bytes E0,F0,75 → a single key_strobe with code=75, ext=1, rel=1; a following 1C gives ext=0, rel=0.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one key_strobe, code=E1, ext=0, rel=0, after the 8th byte.
- Frame 0x1C with parity forced to 1 → frame_err pulse, no raw_strobe or key_strobe. A 1-cycle glitch on ps2_clk (shorter than FILTER) → no bit advance.
- Timeout and reset:
  - With PS2_RX_TIMEOUT_EN: stall after 4 data bits for 2049 cycles → frame_err pulse; the next full 0x1C frame decodes correctly.
  - reset asserted mid-frame → all outputs 0; the next frame decodes cleanly.
